fuse_ctrl_in_stim_player: RTL and testbench

//  Parametrised, timed stimulus player for fuse_ctrl input pins: NumChan independent

---
 rtl/fuse_ctrl_in_stim_player.sv | 168 ++++++++++++++++
 tb/tb_fuse_ctrl_in_stim_player.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fuse_ctrl_in_stim_player.sv
// Timed stimulus player: plays a queue of {chan, data, delay} records onto NumChan pin channels.
// Optional macro FUSE_CTRL_IN_LOOP_EN adds loop_i for continuous replay of the queued records.
module fuse_ctrl_in_stim_player #(
  parameter int               NumChan    = 4,
  parameter int               ChanW      = 32,
  parameter int               Depth      = 8,
  parameter int               DlyW       = 16,
  parameter logic [ChanW-1:0] ChanRstVal = '0,
  localparam int              ChanIdxW   = (NumChan > 1) ? $clog2(NumChan) : 1,
  localparam int              PtrW       = $clog2(Depth),
  localparam int              LvlW       = $clog2(Depth) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [ChanIdxW-1:0]      push_chan_i,
  input  logic [ChanW-1:0]         push_data_i,
  input  logic [DlyW-1:0]          push_dly_i,
  input  logic                     start_i,
  input  logic                     abort_i,
`ifdef FUSE_CTRL_IN_LOOP_EN
  input  logic                     loop_i,
`endif
  output logic                     busy_o,
  output logic [LvlW-1:0]          level_o,
  output logic [NumChan*ChanW-1:0] chan_o,
  output logic [NumChan-1:0]       chan_upd_o,
  output logic                     done_o,
  output logic                     err_o
);

  typedef struct packed {
    logic [ChanIdxW-1:0] chan;
    logic [ChanW-1:0]    data;
    logic [DlyW-1:0]     dly;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  entry_t          mem [Depth];
  entry_t          head_reg;
  entry_t          wr_entry;
  logic [DlyW-1:0] cnt_reg;
  logic [PtrW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [LvlW-1:0] level_reg, level_next;
  logic            done_reg, done_next;
  logic            err_reg;
  logic            loop_reg, loop_sel;
  logic            full, empty, pop, repush, chan_ok, push_ok, wr_en, load_en;

`ifdef FUSE_CTRL_IN_LOOP_EN
  assign loop_sel = loop_i;
`else
  assign loop_sel = 1'b0;
`endif

  assign full    = (level_reg == LvlW'(Depth));
  assign empty   = (level_reg == '0);
  assign pop     = (state_reg == RUN) && (cnt_reg == '0);
  // In loop mode the popped record takes the single write slot, so external pushes wait a cycle.
  assign repush  = pop && loop_reg;
  assign chan_ok = (int'(push_chan_i) < NumChan);
  assign push_ready_o = !full && !repush;
  assign push_ok  = push_valid_i && push_ready_o && chan_ok;
  assign wr_en    = push_ok || repush;
  assign wr_entry = repush ? head_reg : {push_chan_i, push_data_i, push_dly_i};
  assign level_next = level_reg + LvlW'(wr_en) - LvlW'(pop);

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    load_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (!empty) state_next = LOAD;
          else        done_next  = 1'b1;
        end
      end
      LOAD: begin
        load_en    = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (pop) begin
          if (level_next != '0) begin
            state_next = LOAD;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      loop_reg   <= 1'b0;
    end else if (abort_i) begin
      state_reg  <= IDLE;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
      done_reg   <= 1'b0;
      loop_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      done_reg  <= done_next;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
      if (push_valid_i && !chan_ok) err_reg <= 1'b1;
      if (state_reg == IDLE && start_i) loop_reg <= loop_sel;
    end
  end

  // Queue storage and head/delay registers carry no reset; they are only consumed after a LOAD.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_entry;
    if (load_en) begin
      head_reg <= mem[rd_ptr_reg];
      cnt_reg  <= mem[rd_ptr_reg].dly;
    end else if (state_reg == RUN && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - DlyW'(1);
    end
  end

  for (genvar gi = 0; gi < NumChan; gi++) begin : g_chan
    logic [ChanW-1:0] val_reg;
    logic             upd_reg;
    logic             hit;

    assign hit = pop && (head_reg.chan == ChanIdxW'(gi));

    always_ff @(posedge clk_i) begin
      if (rst_i || abort_i) begin
        val_reg <= ChanRstVal;
        upd_reg <= 1'b0;
      end else begin
        upd_reg <= hit;
        if (hit) val_reg <= head_reg.data;
      end
    end

    assign chan_o[gi*ChanW +: ChanW] = val_reg;
    assign chan_upd_o[gi]            = upd_reg;
  end

  assign busy_o  = (state_reg != IDLE);
  assign level_o = level_reg;
  assign done_o  = done_reg;
  assign err_o   = err_reg;

endmodule

// File: tb/tb_fuse_ctrl_in_stim_player.sv
// Self-checking bench for fuse_ctrl_in_stim_player: randomized playback against a timing model.
// The loop scenario is exercised only when FUSE_CTRL_IN_LOOP_EN is defined.
`timescale 1ns/1ps
module tb_fuse_ctrl_in_stim_player;
  localparam logic [31:0] RSTV = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, push_valid = 1'b0, start = 1'b0, abort = 1'b0, loop_en = 1'b0;
  logic [1:0]   push_chan = '0;
  logic [31:0]  push_data = '0;
  logic [15:0]  push_dly = '0;
  logic         push_ready, busy, done, err;
  logic [3:0]   level;
  logic [127:0] chan;
  logic [3:0]   upd;

  logic         s_push_valid = 1'b0, s_start = 1'b0, s_abort = 1'b0;
  logic [1:0]   s_push_chan = '0;
  logic [7:0]   s_push_data = '0;
  logic [3:0]   s_push_dly = '0;
  logic         s_push_ready, s_busy, s_done, s_err;
  logic [1:0]   s_level;
  logic [23:0]  s_chan;
  logic [2:0]   s_upd;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] mdl [4];

  fuse_ctrl_in_stim_player #(.NumChan(4), .ChanW(32), .Depth(8), .DlyW(16), .ChanRstVal(RSTV)) dut (
    .clk_i(clk), .rst_i(rst), .push_valid_i(push_valid), .push_ready_o(push_ready),
    .push_chan_i(push_chan), .push_data_i(push_data), .push_dly_i(push_dly),
    .start_i(start), .abort_i(abort),
`ifdef FUSE_CTRL_IN_LOOP_EN
    .loop_i(loop_en),
`endif
    .busy_o(busy), .level_o(level), .chan_o(chan), .chan_upd_o(upd), .done_o(done), .err_o(err)
  );

  fuse_ctrl_in_stim_player #(.NumChan(3), .ChanW(8), .Depth(2), .DlyW(4), .ChanRstVal(8'h00)) dut_small (
    .clk_i(clk), .rst_i(rst), .push_valid_i(s_push_valid), .push_ready_o(s_push_ready),
    .push_chan_i(s_push_chan), .push_data_i(s_push_data), .push_dly_i(s_push_dly),
    .start_i(s_start), .abort_i(s_abort),
`ifdef FUSE_CTRL_IN_LOOP_EN
    .loop_i(1'b0),
`endif
    .busy_o(s_busy), .level_o(s_level), .chan_o(s_chan), .chan_upd_o(s_upd), .done_o(s_done), .err_o(s_err)
  );

  function automatic logic [127:0] mdl_vec();
    logic [127:0] v;
    for (int c = 0; c < 4; c++) v[c*32 +: 32] = mdl[c];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [31:0] d, input int dly);
    push_valid = 1'b1; push_chan = ch[1:0]; push_data = d; push_dly = dly[15:0];
    step();
    push_valid = 1'b0;
    $display("push ch=%0d data=%08h dly=%0d level=%0d", ch, d, dly, level);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) mdl[c] = RSTV;
  endtask

  task automatic test_reset();
    rst = 1'b1; push_valid = 1'b1; start = 1'b1; push_chan = 2'd1; push_data = 32'hDEAD_BEEF;
    step(); step(); step();
    rst = 1'b0; push_valid = 1'b0; start = 1'b0;
    for (int c = 0; c < 4; c++) mdl[c] = RSTV;
    $display("reset released");
    n_checks++;
    if (chan !== {4{RSTV}}) $display("FAIL reset_chan: got %h want %h", chan, {4{RSTV}}); else n_pass++;
    n_checks++;
    if ({busy, level, push_ready} !== {1'b0, 4'd0, 1'b1})
      $display("FAIL reset_status: busy=%0b level=%0d ready=%0b want 0/0/1", busy, level, push_ready);
    else n_pass++;
    n_checks++;
    if ({upd, done, err} !== 6'd0) $display("FAIL reset_pulses: upd=%b done=%0b err=%0b want 0", upd, done, err);
    else n_pass++;
    n_checks++;
    if ({s_err, s_level, s_push_ready} !== {1'b0, 2'd0, 1'b1})
      $display("FAIL reset_small: err=%0b level=%0d ready=%0b", s_err, s_level, s_push_ready);
    else n_pass++;
  endtask

  task automatic test_timing();
    int n; bit got; logic prev_busy;
    push(2, 32'h0000_1234, 5);
    start = 1'b1; step(); start = 1'b0;
    n = 0; got = 1'b0; prev_busy = busy;
    while (n < 40 && !got) begin
      prev_busy = busy;
      step(); n++;
      if (upd != 4'd0) got = 1'b1;
    end
    $display("timing apply after %0d cycles", n);
    n_checks++;
    if (n !== 7) $display("FAIL timing_latency: got %0d cycles want 7", n); else n_pass++;
    n_checks++;
    if ({upd, chan[64 +: 32], done} !== {4'b0100, 32'h0000_1234, 1'b1})
      $display("FAIL timing_apply: upd=%b chan2=%h done=%0b want 0100/00001234/1", upd, chan[64 +: 32], done);
    else n_pass++;
    n_checks++;
    if (prev_busy !== 1'b1) $display("FAIL timing_busy_before: got %0b want 1", prev_busy); else n_pass++;
    step();
    n_checks++;
    if ({busy, done, upd} !== 6'd0) $display("FAIL timing_after: busy=%0b done=%0b upd=%b want 0", busy, done, upd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int chs [3];
    logic [31:0] ds [3];
    int t, k, ups, prev_lvl; bit dn, acc;
    chs = '{0, 1, 3};
    for (int i = 0; i < 3; i++) begin
      ds[i] = $urandom | 32'h1;
      push(chs[i], ds[i], 0);
    end
    start = 1'b1; step(); start = 1'b0;
    t = 0; k = 0;
    while (t < 30 && k < 3) begin
      step(); t++;
      if (upd != 4'd0) begin
        n_checks++;
        if ({t, upd, chan[chs[k]*32 +: 32]} !== {2*(k+1), 4'(1 << chs[k]), ds[k]})
          $display("FAIL b2b_update%0d: t=%0d upd=%b data=%h want t=%0d ch=%0d data=%h",
                   k, t, upd, chan[chs[k]*32 +: 32], 2*(k+1), chs[k], ds[k]);
        else n_pass++;
        k++;
      end
    end
    n_checks++;
    if (k !== 3) $display("FAIL b2b_count: got %0d updates want 3", k); else n_pass++;
    for (int i = 0; i < 8; i++) push(i % 4, $urandom | 32'h1, 0);
    n_checks++;
    if ({level, push_ready} !== {4'd8, 1'b0})
      $display("FAIL fill_full: level=%0d ready=%0b want 8/0", level, push_ready);
    else n_pass++;
    push_valid = 1'b1; push_chan = 2'd1; push_data = 32'h0000_0909; push_dly = '0;
    step(); step(); step();
    $display("ninth push held level=%0d", level);
    n_checks++;
    if (level !== 4'd8) $display("FAIL fill_hold: level=%0d want 8", level); else n_pass++;
    start = 1'b1; step(); start = 1'b0;
    ups = 0; dn = 1'b0; t = 0;
    while (!dn && t < 80) begin
      acc = push_valid && push_ready;
      step(); t++;
      if (acc) push_valid = 1'b0;
      if (upd != 4'd0) ups++;
      if (done) dn = 1'b1;
    end
    push_valid = 1'b0;
    n_checks++;
    if ({dn, ups} !== {1'b1, 32'd9}) $display("FAIL fill_drain: done=%0b updates=%0d want 1/9", dn, ups);
    else n_pass++;
    push(0, 32'h0000_0A0B, 3);
    push(1, 32'h0000_0C0D, 3);
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step(); step();
    prev_lvl = int'(level);
    push_valid = 1'b1; push_chan = 2'd2; push_data = 32'h0000_0E0F; push_dly = '0;
    step();
    push_valid = 1'b0;
    $display("push+pop same cycle level before=%0d after=%0d", prev_lvl, level);
    n_checks++;
    if ({prev_lvl, level, upd} !== {32'd2, 4'd2, 4'b0001})
      $display("FAIL pushpop_level: before=%0d after=%0d upd=%b want 2/2/0001", prev_lvl, level, upd);
    else n_pass++;
    ups = 0; dn = 1'b0; t = 0;
    while (!dn && t < 40) begin
      step(); t++;
      if (upd != 4'd0) ups++;
      if (done) dn = 1'b1;
    end
    n_checks++;
    if ({dn, ups, chan[64 +: 32]} !== {1'b1, 32'd2, 32'h0000_0E0F})
      $display("FAIL pushpop_drain: done=%0b updates=%0d chan2=%h want 1/2/00000e0f", dn, ups, chan[64 +: 32]);
    else n_pass++;
  endtask

  task automatic test_bad_chan();
    s_push_valid = 1'b1; s_push_chan = 2'd3; s_push_data = 8'h5A;
    step();
    s_push_valid = 1'b0;
    $display("small push ch=3 err=%0b level=%0d", s_err, s_level);
    n_checks++;
    if ({s_err, s_level} !== {1'b1, 2'd0}) $display("FAIL bad_chan: err=%0b level=%0d want 1/0", s_err, s_level);
    else n_pass++;
    s_push_valid = 1'b1; s_push_chan = 2'd1;
    step();
    s_push_valid = 1'b0;
    $display("small push ch=1 err=%0b level=%0d", s_err, s_level);
    n_checks++;
    if ({s_err, s_level} !== {1'b1, 2'd1}) $display("FAIL bad_chan_sticky: err=%0b level=%0d want 1/1", s_err, s_level);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL main_err: got %0b want 0", err); else n_pass++;
  endtask

  task automatic test_abort();
    int bad;
    push(1, 32'h0000_7777, 10);
    push(3, 32'h0000_8888, 0);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    n_checks++;
    if ({busy, level} !== {1'b1, 4'd2}) $display("FAIL abort_pre: busy=%0b level=%0d want 1/2", busy, level);
    else n_pass++;
    abort = 1'b1; push_valid = 1'b1; push_chan = 2'd0; push_data = 32'h0000_9999; push_dly = '0;
    step();
    abort = 1'b0; push_valid = 1'b0;
    for (int c = 0; c < 4; c++) mdl[c] = RSTV;
    $display("abort issued busy=%0b level=%0d", busy, level);
    n_checks++;
    if ({busy, level, done, upd} !== 10'd0)
      $display("FAIL abort_status: busy=%0b level=%0d done=%0b upd=%b want 0", busy, level, done, upd);
    else n_pass++;
    n_checks++;
    if (chan !== mdl_vec()) $display("FAIL abort_chan: got %h want %h", chan, mdl_vec()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (upd != 4'd0 || done || level != 4'd0 || busy) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL abort_quiet: %0d active cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_random();
    int qch [$]; int qdly [$]; logic [31:0] qdat [$];
    int n, idx, t, next_t;
    logic [3:0] eu; logic ed;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      qch.delete(); qdly.delete(); qdat.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        qch.push_back($urandom_range(0, 3));
        qdly.push_back($urandom_range(0, 6));
        qdat.push_back($urandom);
        push(qch[i], qdat[i], qdly[i]);
      end
      n_checks++;
      if (level !== 4'(n)) $display("FAIL rand%0d_level: got %0d want %0d", r, level, n); else n_pass++;
      start = 1'b1; step(); start = 1'b0;
      idx = 0; t = 0; next_t = qdly[0] + 2;
      while (idx < n) begin
        step(); t++;
        eu = '0; ed = 1'b0;
        if (t == next_t) begin
          mdl[qch[idx]] = qdat[idx];
          eu[qch[idx]] = 1'b1;
          idx++;
          if (idx == n) ed = 1'b1;
          else next_t = t + qdly[idx] + 2;
        end
        n_checks++;
        if ({chan, upd, done, level} !== {mdl_vec(), eu, ed, 4'(n - idx)})
          $display("FAIL rand%0d_t%0d: chan=%h upd=%b done=%0b level=%0d want chan=%h upd=%b done=%0b level=%0d",
                   r, t, chan, upd, done, level, mdl_vec(), eu, ed, n - idx);
        else n_pass++;
      end
      step();
      n_checks++;
      if ({busy, done} !== 2'b00) $display("FAIL rand%0d_idle: busy=%0b done=%0b want 0/0", r, busy, done);
      else n_pass++;
    end
  endtask

`ifdef FUSE_CTRL_IN_LOOP_EN
  task automatic test_loop();
    int lch [2]; int ldly [2]; logic [31:0] ldat [2];
    int idx, t, next_t;
    logic [3:0] eu;
    do_reset();
    lch = '{0, 2}; ldly = '{1, 2};
    ldat[0] = $urandom | 32'h1; ldat[1] = $urandom | 32'h1;
    push(lch[0], ldat[0], ldly[0]);
    push(lch[1], ldat[1], ldly[1]);
    loop_en = 1'b1; start = 1'b1; step(); start = 1'b0; loop_en = 1'b0;
    idx = 0; t = 0; next_t = ldly[0] + 2;
    while (idx < 8) begin
      step(); t++;
      eu = '0;
      if (t == next_t) begin
        mdl[lch[idx % 2]] = ldat[idx % 2];
        eu[lch[idx % 2]] = 1'b1;
        idx++;
        next_t = t + ldly[idx % 2] + 2;
      end
      n_checks++;
      if ({chan, upd, done, level} !== {mdl_vec(), eu, 1'b0, 4'd2})
        $display("FAIL loop_t%0d: chan=%h upd=%b done=%0b level=%0d want upd=%b done=0 level=2",
                 t, chan, upd, done, level, eu);
      else n_pass++;
    end
    abort = 1'b1; step(); abort = 1'b0;
    for (int c = 0; c < 4; c++) mdl[c] = RSTV;
    $display("loop aborted busy=%0b level=%0d", busy, level);
    n_checks++;
    if ({busy, level, chan} !== {1'b0, 4'd0, mdl_vec()})
      $display("FAIL loop_abort: busy=%0b level=%0d chan=%h", busy, level, chan);
    else n_pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timing();
    test_back_to_back();
    test_bad_chan();
    test_abort();
    test_random();
`ifdef FUSE_CTRL_IN_LOOP_EN
    test_loop();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
